mode_fsm_gen: RTL and testbench
===============================

MODE_FSM_GEN -- requirements
Module: mode_fsm_gen

Interface
REQ-001 SHALL have parameter N_MODES, default 5, number of selectable modes (2..15), one switch per mode.
REQ-002 SHALL have parameter CLK_FREQ_HZ, default 50_000_000, clock frequency in Hz.
REQ-003 SHALL have parameter BLINK_HZ, default 4, error blink frequency in Hz.
REQ-004 SHALL have parameter ERR_TOGGLES, default 8, number of blink_bit toggles before an error auto-clears.
REQ-005 SHALL derive localparam MW = clog2(N_MODES+1) and HALF = CLK_FREQ_HZ/(2*BLINK_HZ).
REQ-006 SHALL use one clock and a synchronous, active-low reset.
REQ-007 clk  input  1  system clock; all logic on rising edge.
REQ-008 rst_n  input  1  synchronous active-low reset.
REQ-009 btn_pulse  input  1  debounced single-cycle confirm pulse.
REQ-010 mode_sw  input  N_MODES  mode select switches; valid only when exactly one bit is set.
REQ-011 exit_req  input  1  single-cycle done pulse from the active mode's datapath.
REQ-012 mode_state  output  MW  0 = default, k = mode index k-1 active.
REQ-013 error_active  output  1  high while in ERROR.
REQ-014 blink_bit  output  1  blink phase; toggles every HALF cycles in ERROR, 0 otherwise.
REQ-015 mode_enter  output  1  single-cycle pulse on entry to ACTIVE.
REQ-016 mode_exit  output  1  single-cycle pulse on return from ACTIVE to IDLE.

Function
REQ-017 SHALL implement the states IDLE, ACTIVE and ERROR; all outputs SHALL be registered and update on the clock edge following the causing input (1-cycle latency).
REQ-018 IDLE + btn_pulse + one-hot mode_sw at bit i -> ACTIVE, mode_state = i+1, mode_enter = 1 for one cycle.
REQ-019 IDLE + btn_pulse + non-one-hot mode_sw (zero or multiple bits) -> ERROR, blink_bit = 1, toggle count = 0, timer = 0.
REQ-020 IDLE without btn_pulse SHALL hold state; mode_sw changes alone SHALL have no effect.
REQ-021 ACTIVE SHALL latch mode_state; mode_sw changes SHALL be ignored.
REQ-022 ACTIVE + exit_req -> IDLE, mode_state = 0, mode_exit = 1 for one cycle.
REQ-023 ACTIVE + btn_pulse with mode_sw == 0 -> IDLE with mode_exit; btn_pulse with any other mode_sw value SHALL be ignored.
REQ-024 ACTIVE + exit_req and btn_pulse in the same cycle SHALL be handled as exit_req only (single mode_exit pulse).
REQ-025 ERROR: the timer counts 0..HALF-1; at HALF-1, blink_bit toggles, the timer wraps to 0 and the toggle count increments.
REQ-026 ERROR: the toggle that brings the count to ERR_TOGGLES -> IDLE, error_active = 0, blink_bit = 0.
REQ-027 ERROR + btn_pulse + one-hot mode_sw -> ACTIVE directly (as REQ-018, with mode_enter); error_active and blink_bit clear in the same edge.
REQ-028 ERROR + btn_pulse + non-one-hot mode_sw SHALL restart the error: timer = 0, count = 0, blink_bit = 1.
REQ-029 btn_pulse coincident with the auto-clear edge SHALL take priority over the auto-clear (REQ-027/028 apply).
REQ-030 mode_enter and mode_exit SHALL never be high in the same cycle.
REQ-031 mode_state SHALL never exceed N_MODES.

Reset
REQ-032 rst_n low at a clock edge -> IDLE; mode_state = 0; error_active, blink_bit, mode_enter, mode_exit = 0; timer and count = 0.
REQ-033 Reset SHALL take effect mid-ACTIVE or mid-ERROR without generating a mode_exit pulse.

Structure
REQ-034 The state encoding (IDLE = 0, ACTIVE = 1, ERROR = 2) and the one-hot-check/index function SHALL reside in the shared package mode_pkg.
REQ-035 The blink timer and toggle counter SHALL be a sub-module blink_timer with inputs start and stop and outputs blink_bit and done.

Verification (N_MODES = 5, CLK_FREQ_HZ = 16, BLINK_HZ = 2 -> HALF = 4, ERR_TOGGLES = 4)
REQ-036 Stimulus: mode_sw = 00100, btn_pulse. Required response: mode_state = 3 and mode_enter = 1 for exactly one cycle, one cycle later.
REQ-037 Stimulus: mode_sw = 00110, btn_pulse. Required response: error_active = 1; blink_bit toggles every 4 cycles; IDLE after 16 cycles with error_active = 0.
REQ-038 Stimulus: in ERROR, set mode_sw = 10000 and pulse btn. Required response: mode_state = 5, error_active = 0, mode_enter = 1.
REQ-039 Stimulus: in ACTIVE mode 2, assert exit_req and btn_pulse in the same cycle. Required response: mode_state = 0 and a single mode_exit pulse.
REQ-040 Stimulus: in ACTIVE, change mode_sw to 01000 and pulse btn. Required response: mode_state unchanged and no pulses.
REQ-041 Stimulus: assert rst_n = 0 mid-ERROR. Required response: all outputs 0 at the next edge and no mode_exit pulse.

Source files
------------

// File: rtl/mode_pkg.sv
// Shared state encoding and mode-switch decode helpers for mode_fsm_gen.
package mode_pkg;

    // Widest switch bank any instance may use; narrower banks are zero-extended.
    localparam int unsigned MAX_MODES = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERROR  = 2'd2
    } state_t;

    typedef logic [MAX_MODES-1:0] sw_vec_t;

    // True when exactly one switch is set.
    function automatic logic is_onehot(input sw_vec_t v);
        return (v != '0) && ((v & (v - sw_vec_t'(1))) == '0);
    endfunction

    // Bit position of the set switch; only meaningful when is_onehot(v).
    function automatic logic [3:0] onehot_index(input sw_vec_t v);
        logic [3:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_MODES; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Error blink generator: half-period timer plus toggle counter with auto-done.
module blink_timer #(
    parameter int unsigned HALF        = 4,
    parameter int unsigned ERR_TOGGLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic stop,
    output logic blink_bit,
    output logic done
);

    localparam int unsigned TW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned CW = $clog2(ERR_TOGGLES + 1);

    logic          run_q,   run_d;
    logic [TW-1:0] tmr_q,   tmr_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          blink_q, blink_d;
    logic          wrap;

    assign wrap      = run_q && (tmr_q == TW'(HALF - 1));
    // done is combinational so the owning FSM can leave ERROR on the same edge
    // as the final toggle.
    assign done      = wrap && (cnt_q == CW'(ERR_TOGGLES - 1));
    assign blink_bit = blink_q;

    // Next-state for timer, toggle count and blink phase; start beats stop.
    always_comb begin
        run_d   = run_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (start) begin
            run_d   = 1'b1;
            tmr_d   = '0;
            cnt_d   = '0;
            blink_d = 1'b1;
        end else if (stop) begin
            run_d   = 1'b0;
            tmr_d   = '0;
            cnt_d   = '0;
            blink_d = 1'b0;
        end else if (run_q) begin
            if (wrap) begin
                tmr_d = '0;
                if (done) begin
                    run_d   = 1'b0;
                    cnt_d   = '0;
                    blink_d = 1'b0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    blink_d = ~blink_q;
                end
            end else begin
                tmr_d = tmr_q + TW'(1);
            end
        end
    end

    // Timer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            tmr_q   <= '0;
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            run_q   <= run_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

endmodule

// File: rtl/mode_fsm_gen.sv
// Mode selection FSM: confirms a one-hot switch choice into ACTIVE, flags bad
// selections with a self-clearing blinking ERROR state.
module mode_fsm_gen
    import mode_pkg::*;
#(
    parameter int unsigned N_MODES     = 5,
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BLINK_HZ    = 4,
    parameter int unsigned ERR_TOGGLES = 8,
    localparam int unsigned MW         = $clog2(N_MODES + 1),
    localparam int unsigned HALF       = CLK_FREQ_HZ / (2 * BLINK_HZ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_pulse,
    input  logic [N_MODES-1:0] mode_sw,
    input  logic               exit_req,
    output logic [MW-1:0]      mode_state,
    output logic               error_active,
    output logic               blink_bit,
    output logic               mode_enter,
    output logic               mode_exit
);

    state_t          state_q, state_d;
    logic [MW-1:0]   mode_q,  mode_d;
    logic            enter_q, enter_d;
    logic            exit_q,  exit_d;
    logic            tmr_start, tmr_stop, tmr_done;
    sw_vec_t         sw_ext;
    logic            sw_ok;
    logic [MW-1:0]   sw_mode;

    assign sw_ext  = sw_vec_t'(mode_sw);
    assign sw_ok   = is_onehot(sw_ext);
    assign sw_mode = MW'(onehot_index(sw_ext)) + MW'(1);

    blink_timer #(
        .HALF        (HALF),
        .ERR_TOGGLES (ERR_TOGGLES)
    ) u_blink (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (tmr_start),
        .stop      (tmr_stop),
        .blink_bit (blink_bit),
        .done      (tmr_done)
    );

    // Next-state, latched mode and entry/exit pulse decode.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        enter_d   = 1'b0;
        exit_d    = 1'b0;
        tmr_start = 1'b0;
        tmr_stop  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_pulse) begin
                    if (sw_ok) begin
                        state_d = ACTIVE;
                        mode_d  = sw_mode;
                        enter_d = 1'b1;
                    end else begin
                        state_d   = ERROR;
                        tmr_start = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (exit_req || (btn_pulse && (mode_sw == '0))) begin
                    state_d = IDLE;
                    mode_d  = '0;
                    exit_d  = 1'b1;
                end
            end
            ERROR: begin
                // A confirm press outranks the auto-clear on the same edge.
                if (btn_pulse) begin
                    if (sw_ok) begin
                        state_d  = ACTIVE;
                        mode_d   = sw_mode;
                        enter_d  = 1'b1;
                        tmr_stop = 1'b1;
                    end else begin
                        tmr_start = 1'b1;
                    end
                end else if (tmr_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                mode_d   = '0;
                tmr_stop = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= '0;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
        end
    end

    assign mode_state   = mode_q;
    assign error_active = (state_q == ERROR);
    assign mode_enter   = enter_q;
    assign mode_exit    = exit_q;

endmodule

// File: tb/tb_mode_fsm_gen.sv
// Scoreboard bench for mode_fsm_gen: a cycle model pushes expected outputs,
// a monitor pops and compares them on the falling edge.
module tb_mode_fsm_gen;

    localparam int N    = 5;
    localparam int HALF = 4;
    localparam int TOG  = 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         btn_pulse = 1'b0;
    logic         exit_req  = 1'b0;
    logic [N-1:0] mode_sw   = '0;
    logic [2:0]   mode_state;
    logic         error_active, blink_bit, mode_enter, mode_exit;

    typedef struct packed {
        logic [2:0] mode;
        logic       err;
        logic       blink;
        logic       enter;
        logic       ext;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    mode_fsm_gen #(
        .N_MODES     (N),
        .CLK_FREQ_HZ (16),
        .BLINK_HZ    (2),
        .ERR_TOGGLES (TOG)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_pulse    (btn_pulse),
        .mode_sw      (mode_sw),
        .exit_req     (exit_req),
        .mode_state   (mode_state),
        .error_active (error_active),
        .blink_bit    (blink_bit),
        .mode_enter   (mode_enter),
        .mode_exit    (mode_exit)
    );

    always #5 clk = ~clk;

    // Reference model: mode number, and for ERROR the cycles elapsed since it
    // (re)started; blink phase and auto-clear follow from that count alone.
    initial begin : model
        int   st, md, el, ones, idx;
        logic en, ex;
        exp_t e;
        st = 0; md = 0; el = 0;
        forever begin
            @(posedge clk);
            ones = $countones(mode_sw);
            idx  = 0;
            for (int i = 0; i < N; i++) if (mode_sw[i]) idx = i;
            en = 1'b0; ex = 1'b0;
            if (!rst_n) begin
                st = 0; md = 0; el = 0;
            end else if (st == 0) begin
                if (btn_pulse) begin
                    if (ones == 1) begin st = 1; md = idx + 1; en = 1'b1; end
                    else begin st = 2; el = 0; end
                end
            end else if (st == 1) begin
                if (exit_req || (btn_pulse && mode_sw == 0)) begin
                    st = 0; md = 0; ex = 1'b1;
                end
            end else begin
                if (btn_pulse) begin
                    if (ones == 1) begin st = 1; md = idx + 1; en = 1'b1; end
                    else el = 0;
                end else begin
                    el++;
                    if (el == TOG * HALF) st = 0;
                end
            end
            e.mode  = 3'(md);
            e.err   = (st == 2);
            e.blink = (st == 2) && ((el / HALF) % 2 == 0);
            e.enter = en;
            e.ext   = ex;
            exp_q.push_back(e);
        end
    end

    // Monitor: compare every presented output cycle against the scoreboard.
    initial begin : monitor
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {mode_state, error_active, blink_bit, mode_enter, mode_exit};
                n_checks++;
                if (a === e && !(mode_enter && mode_exit)) n_pass++;
                else $display("FAIL outputs t=%0t: got mode=%0d err=%b blink=%b enter=%b exit=%b, want mode=%0d err=%b blink=%b enter=%b exit=%b",
                              $time, a.mode, a.err, a.blink, a.enter, a.ext,
                              e.mode, e.err, e.blink, e.enter, e.ext);
            end
        end
    end

    task automatic cyc(input logic b, input logic [N-1:0] s, input logic x, input logic r);
        @(negedge clk);
        btn_pulse = b;
        mode_sw   = s;
        exit_req  = x;
        rst_n     = r;
    endtask

    task automatic idle(input int n, input logic [N-1:0] s);
        for (int i = 0; i < n; i++) cyc(1'b0, s, 1'b0, 1'b1);
    endtask

    function automatic logic [N-1:0] rand_sw();
        int unsigned k;
        k = $urandom_range(0, 3);
        if (k <= 1) return N'(1 << $urandom_range(0, N - 1));
        if (k == 2) return N'($urandom);
        return '0;
    endfunction

    initial begin : stim
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        idle(3, 5'b00101);
        // one-hot confirm into mode 3
        cyc(1'b1, 5'b00100, 1'b0, 1'b1);
        idle(3, 5'b00100);
        // switch change plus press while active is ignored
        idle(2, 5'b01000);
        cyc(1'b1, 5'b01000, 1'b0, 1'b1);
        idle(2, 5'b01000);
        // press with switches cleared exits
        cyc(1'b1, 5'b00000, 1'b0, 1'b1);
        idle(2, '0);
        // bad selection: full error cycle and auto-clear
        cyc(1'b1, 5'b00110, 1'b0, 1'b1);
        idle(20, 5'b00110);
        // error then direct entry to mode 5
        cyc(1'b1, 5'b00000, 1'b0, 1'b1);
        idle(6, '0);
        cyc(1'b1, 5'b10000, 1'b0, 1'b1);
        idle(2, 5'b10000);
        cyc(1'b0, 5'b10000, 1'b1, 1'b1);
        idle(2, '0);
        // mode 2, exit_req and btn together
        cyc(1'b1, 5'b00010, 1'b0, 1'b1);
        idle(2, 5'b00010);
        cyc(1'b1, 5'b00000, 1'b1, 1'b1);
        idle(3, '0);
        // error restart mid-blink
        cyc(1'b1, 5'b11000, 1'b0, 1'b1);
        idle(9, '0);
        cyc(1'b1, 5'b11000, 1'b0, 1'b1);
        idle(18, '0);
        // press exactly on the auto-clear edge: good then bad selection
        cyc(1'b1, 5'b00000, 1'b0, 1'b1);
        idle(TOG * HALF - 1, '0);
        cyc(1'b1, 5'b00001, 1'b0, 1'b1);
        idle(2, '0);
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b1, 5'b00000, 1'b0, 1'b1);
        idle(TOG * HALF - 1, '0);
        cyc(1'b1, 5'b01100, 1'b0, 1'b1);
        idle(5, '0);
        // reset mid-error, then mid-active
        cyc(1'b0, '0, 1'b0, 1'b0);
        idle(3, '0);
        cyc(1'b1, 5'b01000, 1'b0, 1'b1);
        idle(2, '0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        idle(3, '0);
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 3) == 0), rand_sw(),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) != 0));
        end
        idle(3, '0);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() <= 1) n_pass++;
        else $display("FAIL drain: %0d expectations left, want at most 1", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
